// File: rtl/lenet_frame_sched.sv
// lenet_frame_sched
//   Frame-level sequencer for the LeNet accelerator. Tracks two ping-pong
//   input buffers filled by the host loader, launches one inference per
//   loaded buffer in strict alternating order, follows the accelerator
//   through its conv/fc1/fc2 phases and hands the result to the host over a
//   valid/ready handshake. A per-phase watchdog and a sticky error flag
//   guard against hung or misbehaving accelerator/host traffic.
//
// Ports
//   clk, srst          : clock, synchronous active-high reset
//   load_done/load_buf : host finished filling buffer load_buf (1-cycle pulse)
//   buf_free[1:0]      : bit i set when buffer i may be loaded by the host
//   conv_start         : 1-cycle start pulse to the accelerator
//   in_sel             : input buffer set the accelerator reads (SRAM A)
//   conv_done, fc1_done, fc2_done : phase-done pulses from the accelerator
//   result_valid/result_ready     : result handshake to the host
//   busy               : a frame is in flight (START..RESULT)
//   timeout_cycles     : watchdog limit per phase, 0 disables
//   err, err_code      : sticky error, 01 timeout / 10 protocol / 11 overwrite
//   clear_err          : leave the error state
//   frame_cnt          : completed frames, wraps
module lenet_frame_sched #(
   parameter int unsigned TIMEOUT_W   = 20,
   parameter int unsigned FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   load_done,
   input  logic                   load_buf,
   output logic [1:0]             buf_free,
   output logic                   conv_start,
   output logic                   in_sel,
   input  logic                   conv_done,
   input  logic                   fc1_done,
   input  logic                   fc2_done,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic                   busy,
   input  logic [TIMEOUT_W-1:0]   timeout_cycles,
   output logic                   err,
   output logic [1:0]             err_code,
   input  logic                   clear_err,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_CONV,
      S_FC1,
      S_FC2,
      S_RESULT,
      S_ERR
   } state_t;

   localparam logic [TIMEOUT_W-1:0]   WD_ONE  = TIMEOUT_W'(1);
   localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

   state_t                 state, state_nx;
   logic [1:0]             pend, pend_nx;
   logic [1:0]             buf_free_nx;
   logic                   next_rd, next_rd_nx;
   logic                   in_sel_nx;
   logic [1:0]             err_code_nx;
   logic                   err_in_frame, err_in_frame_nx;
   logic [TIMEOUT_W-1:0]   wd, wd_nx;
   logic [FRAME_CNT_W-1:0] frame_cnt_nx;

   logic in_phase;
   logic exp_done;
   logic unexp_done;
   logic overwrite;
   logic wd_expire;

   // Event decode for the current state.
   always_comb begin
      in_phase = (state == S_CONV) || (state == S_FC1) || (state == S_FC2);
      exp_done = 1'b0;
      case (state)
         S_CONV:  exp_done = conv_done;
         S_FC1:   exp_done = fc1_done;
         S_FC2:   exp_done = fc2_done;
         default: exp_done = 1'b0;
      endcase
      unexp_done = (conv_done && (state != S_CONV)) ||
                   (fc1_done  && (state != S_FC1))  ||
                   (fc2_done  && (state != S_FC2));
      overwrite  = load_done && !buf_free[load_buf];
      // An expected done on the final watchdog cycle takes precedence.
      wd_expire  = in_phase && (timeout_cycles != '0) &&
                   (wd == (timeout_cycles - WD_ONE)) && !exp_done;
   end

   // Next-state and next-register logic.
   always_comb begin
      state_nx        = state;
      pend_nx         = pend;
      buf_free_nx     = buf_free;
      next_rd_nx      = next_rd;
      in_sel_nx       = in_sel;
      err_code_nx     = err_code;
      err_in_frame_nx = err_in_frame;
      frame_cnt_nx    = frame_cnt;

      if ((state != S_ERR) && (overwrite || unexp_done || wd_expire)) begin
         // Error entry pre-empts any normal transition in the same cycle.
         state_nx        = S_ERR;
         err_code_nx     = overwrite ? 2'b11 : (unexp_done ? 2'b10 : 2'b01);
         err_in_frame_nx = (state != S_IDLE);
      end else begin
         case (state)
            S_IDLE: begin
               if (pend[next_rd]) begin
                  in_sel_nx        = next_rd;
                  pend_nx[next_rd] = 1'b0;
                  state_nx         = S_START;
               end
            end
            S_START: state_nx = S_CONV;
            S_CONV: begin
               if (conv_done) begin
                  state_nx            = S_FC1;
                  buf_free_nx[in_sel] = 1'b1;
               end
            end
            S_FC1: if (fc1_done) state_nx = S_FC2;
            S_FC2: if (fc2_done) state_nx = S_RESULT;
            S_RESULT: begin
               if (result_ready) begin
                  state_nx     = S_IDLE;
                  frame_cnt_nx = frame_cnt + CNT_ONE;
                  next_rd_nx   = ~next_rd;
               end
            end
            S_ERR: begin
               if (clear_err) begin
                  state_nx        = S_IDLE;
                  err_code_nx     = 2'b00;
                  err_in_frame_nx = 1'b0;
                  // Only a frame that had left IDLE is dropped.
                  if (err_in_frame) begin
                     buf_free_nx[in_sel] = 1'b1;
                     next_rd_nx          = ~next_rd;
                  end
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end

      // Valid loads are honoured in every state, layered on top of the
      // transition updates above; the check uses the registered buf_free.
      if (load_done && buf_free[load_buf]) begin
         buf_free_nx[load_buf] = 1'b0;
         pend_nx[load_buf]     = 1'b1;
      end

      if (state_nx != state) begin
         wd_nx = '0;
      end else if (in_phase) begin
         wd_nx = wd + WD_ONE;
      end else begin
         wd_nx = wd;
      end
   end

   // State register; outputs are registered from the next-state values so
   // they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (srst) begin
         state        <= S_IDLE;
         pend         <= '0;
         buf_free     <= '1;
         next_rd      <= 1'b0;
         in_sel       <= 1'b0;
         err_code     <= '0;
         err_in_frame <= 1'b0;
         wd           <= '0;
         frame_cnt    <= '0;
         conv_start   <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_nx;
         pend         <= pend_nx;
         buf_free     <= buf_free_nx;
         next_rd      <= next_rd_nx;
         in_sel       <= in_sel_nx;
         err_code     <= err_code_nx;
         err_in_frame <= err_in_frame_nx;
         wd           <= wd_nx;
         frame_cnt    <= frame_cnt_nx;
         conv_start   <= (state_nx == S_START);
         result_valid <= (state_nx == S_RESULT);
         busy         <= (state_nx == S_START) || (state_nx == S_CONV) ||
                         (state_nx == S_FC1)   || (state_nx == S_FC2)  ||
                         (state_nx == S_RESULT);
         err          <= (state_nx == S_ERR);
      end
   end

endmodule
